// File: rtl/rr_pkg.sv
// rr_pkg: shared helpers for the round-robin arbiter
package rr_pkg;
   // Width of a requester index. It is at least 1 because REQCNT is at least 2.
   function automatic int numw(input int reqcnt);
      return $clog2(reqcnt);
   endfunction
endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: rotating priority encoder, finds first set bit after start_i (wrapping)
//   req_i   : request vector
//   start_i : last granted index; search begins at start_i+1
//   idx_o   : first requester found in rotated order
//   any_o   : any request bit set
module rr_prio_enc import rr_pkg::*; #(
   parameter int REQCNT = 20,
   parameter int NUMW   = numw(REQCNT)
) (
   input  logic [REQCNT-1:0] req_i,
   input  logic [NUMW-1:0]   start_i,
   output logic [NUMW-1:0]   idx_o,
   output logic              any_o
);
   logic [NUMW-1:0] hi_idx, lo_idx;
   logic            hi_found;
   // Scan downward so the lowest qualifying index is the last one written.
   // hi_* covers bits above the pointer; lo_idx is the wrap-around fallback.
   always_comb begin
      hi_idx   = '0;
      lo_idx   = '0;
      hi_found = 1'b0;
      for (int i = REQCNT - 1; i >= 0; i--) begin
         if (req_i[i]) lo_idx = NUMW'(i);
         if (req_i[i] && i > int'(start_i)) begin
            hi_idx   = NUMW'(i);
            hi_found = 1'b1;
         end
      end
   end
   assign idx_o = hi_found ? hi_idx : lo_idx;
   assign any_o = |req_i;
endmodule

// File: rtl/rr_top.sv
// rr_top: round-robin arbiter with registered grant index
//   clk_i     : clock
//   rst_i     : asynchronous active-low reset
//   req_i     : request vector
//   req_val_i : qualifier; arbitration only when high
//   req_num_o : last granted index, which is also the round-robin pointer
module rr_top import rr_pkg::*; #(
   parameter int REQCNT = 20,
   parameter int NUMW   = numw(REQCNT)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REQCNT-1:0] req_i,
   input  logic              req_val_i,
   output logic [NUMW-1:0]   req_num_o
);
   logic [NUMW-1:0] req_num_q, req_num_d, found;
   logic            any;
   rr_prio_enc #(.REQCNT(REQCNT), .NUMW(NUMW)) u_enc (
      .req_i  (req_i),
      .start_i(req_num_q),
      .idx_o  (found),
      .any_o  (any)
   );
   assign req_num_d = (req_val_i && any) ? found : req_num_q;
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) req_num_q <= '0;
      else        req_num_q <= req_num_d;
   assign req_num_o = req_num_q;
endmodule

// File: tb/tb_rr_top.sv
// tb_rr_top: directed and random checks of rr_top against a rotating-search model
module tb_rr_top;
   localparam int N = 20;
   logic         clk_i, rst_i, req_val_i;
   logic [N-1:0] req_i;
   logic [4:0]   req_num_o;
   int           n_cmp = 0, n_fail = 0;
   int           m_ptr = 0;
   logic [N-1:0] s_req = '0;
   logic         s_arb = 1'b0;
   rr_top #(.REQCNT(N)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_i),
      .req_val_i(req_val_i),
      .req_num_o(req_num_o)
   );
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // Walk indices p+1, p+2, ... p (mod N) and take the first requester.
   function automatic int rr_next(input int p, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return p;
   endfunction
   always @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         m_ptr <= 0;
         s_arb <= 1'b0;
      end else begin
         s_req <= req_i;
         s_arb <= req_val_i && (req_i != '0);
         if (req_val_i && req_i != '0) m_ptr <= rr_next(m_ptr, req_i);
      end
   always @(negedge clk_i)
      if (rst_i) begin
         chk("model", int'(req_num_o), m_ptr);
         if (s_arb) chk("grant_on_set_bit", int'(req_num_o < 5'(N) && s_req[req_num_o]), 1);
      end
   task automatic step();
      @(negedge clk_i);
   endtask
   task automatic mid_reset();
      #2 rst_i = 1'b0;
      #1 chk("async_reset", int'(req_num_o), 0);
      rst_i = 1'b1;
   endtask
   int w[N];
   int wmax, clr;
   initial begin
      rst_i = 1'b0; req_i = '1; req_val_i = 1'b1;
      repeat (2) step();
      chk("held_reset", int'(req_num_o), 0);
      #2 rst_i = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("post_reset_seq", int'(req_num_o), i);
      end
      mid_reset();
      step();
      chk("after_mid_reset", int'(req_num_o), 1);
      step();
      mid_reset();
      req_i = '1;
      for (int i = 0; i < N; i++) begin
         step();
         chk("all_req_order", int'(req_num_o), (i + 1) % N);
         req_i[req_num_o] = 1'b0;
      end
      chk("all_req_empty", int'(req_i == '0), 1);
      step();
      chk("all_req_hold", int'(req_num_o), 0);
      req_i = N'(1) << 18;
      step();
      chk("wrap_setup", int'(req_num_o), 18);
      req_i = (N'(1) << 19) | (N'(1) << 2);
      step();
      chk("wrap_19", int'(req_num_o), 19);
      step();
      chk("wrap_2", int'(req_num_o), 2);
      req_i = N'(1) << 19;
      step();
      req_i = N'(1);
      step();
      chk("wrap_to_0", int'(req_num_o), 0);
      req_i = N'(1) << 7;
      repeat (4) begin
         step();
         chk("single_7", int'(req_num_o), 7);
      end
      req_i = N'(1) << 5;
      step();
      req_i = N'('h00F00);
      req_val_i = 1'b0;
      repeat (3) begin
         step();
         chk("val_low_hold", int'(req_num_o), 5);
      end
      req_val_i = 1'b1;
      step();
      chk("val_high_8", int'(req_num_o), 8);
      for (int i = 0; i < N; i++) w[i] = 0;
      wmax = 0;
      clr = -1;
      req_i = N'($urandom) | N'(3);
      for (int c = 0; c < 300; c++) begin
         step();
         if (s_arb)
            for (int i = 0; i < N; i++) begin
               w[i] = (s_req[i] && i != int'(req_num_o)) ? w[i] + 1 : 0;
               if (w[i] > wmax) wmax = w[i];
            end
         if (clr >= 0) req_i[clr] = 1'b1;
         if ($urandom_range(0, 3) == 0) req_i[$urandom_range(0, N - 1)] = 1'b1;
         clr = int'(req_num_o);
         if (clr < N) req_i[clr] = 1'b0;
      end
      $display("random phase max wait %0d cycles", wmax);
      chk("fairness_bound", int'(wmax < N), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
